// File: rtl/gsau_wb_drain.sv
// gsau_wb_drain: buffers 512-bit GSAU result rows and serialises them onto the VRF write port.
// Latency: a row pushed at edge t drives its first beat two cycles later from idle; rows that are already queued follow with no bubble.
// Backpressure: wb_output_ready = !full; vrf_ready stalls the current beat and holds it stable.
// Ports: wb_* is the upstream row input, vrf_* is the beat-wise register-file write port,
//        sb_wb_done/sb_wb_dst pulse once per completed row, and busy means work is queued or in flight.

// Generic synchronous FIFO. The entry at head_dat is valid whenever empty=0.
// Latency: a pushed entry becomes visible at head_dat after one edge. There is no bypass.
// Backpressure: the caller must not push when full or pop when empty.
module gsau_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_dat
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_vld, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; the entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign head_dat = mem_q[rd_ptr_q];
endmodule

module gsau_wb_drain #(
  parameter int DATA_W     = 512,
  parameter int BEAT_W     = 128,
  parameter int VEGGIEREGS = 256,
  parameter int DEPTH      = 2,
  localparam int AW     = $clog2(VEGGIEREGS),
  localparam int NBEATS = DATA_W / BEAT_W,
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_wbdst,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_output_ready,
  output logic              vrf_wen,
  output logic [AW-1:0]     vrf_waddr,
  output logic [BW-1:0]     vrf_wbeat,
  output logic [BEAT_W-1:0] vrf_wdata,
  output logic              vrf_wlast,
  input  logic              vrf_ready,
  output logic              sb_wb_done,
  output logic [AW-1:0]     sb_wb_dst,
  output logic              busy
);
  // The data field is viewed as an array of beats so that beat k is simply data[k].
  typedef struct packed {
    logic [AW-1:0]                 dst;
    logic [NBEATS-1:0][BEAT_W-1:0] data;
  } row_t;

  typedef enum logic {IDLE, SEND} state_t;

  row_t          push_row, head;
  logic          full, empty, push, pop, hs, last;
  logic [CW-1:0] cnt;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          done_q, done_d;
  logic [AW-1:0] done_dst_q, done_dst_d;

  assign push_row = '{dst: wb_wbdst, data: wb_data};

  gsau_wb_fifo #(.WIDTH($bits(row_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push_vld (push),
    .push_dat (push_row),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .count    (cnt),
    .head_dat (head)
  );

  // Readiness depends only on occupancy, which keeps the upstream handshake free of combinational paths.
  assign wb_output_ready = !RST && !full;
  assign push = wb_valid && wb_output_ready;
  assign hs   = (state_q == SEND) && vrf_ready;
  assign last = (beat_q == BW'(NBEATS - 1));
  assign pop  = hs && last;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    done_d     = 1'b0;
    done_dst_d = done_dst_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = SEND;
          beat_d  = '0;
        end
      end
      SEND: begin
        if (hs) begin
          if (last) begin
            beat_d     = '0;
            done_d     = 1'b1;
            done_dst_d = head.dst;
            // After the pop the occupancy is cnt-1+push. Stay in SEND unless that reaches zero.
            if (cnt == CW'(1) && !push) state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      done_q     <= 1'b0;
      done_dst_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      done_q     <= done_d;
      done_dst_q <= done_dst_d;
    end
  end

  // Every output is forced to zero while RST is high. The beat fields also read zero when no beat is offered.
  assign vrf_wen    = !RST && (state_q == SEND);
  assign vrf_waddr  = vrf_wen ? head.dst : '0;
  assign vrf_wbeat  = vrf_wen ? beat_q : '0;
  assign vrf_wdata  = vrf_wen ? head.data[beat_q] : '0;
  assign vrf_wlast  = vrf_wen && last;
  assign sb_wb_done = !RST && done_q;
  assign sb_wb_dst  = sb_wb_done ? done_dst_q : '0;
  assign busy       = !RST && ((cnt != '0) || (state_q == SEND));
endmodule

// File: tb/tb_gsau_wb_drain.sv
module tb_gsau_wb_drain;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wb_valid = 1'b0;
  logic [7:0]   wb_wbdst = '0;
  logic [511:0] wb_data = '0;
  logic         wb_output_ready;
  logic         vrf_wen;
  logic [7:0]   vrf_waddr;
  logic [1:0]   vrf_wbeat;
  logic [127:0] vrf_wdata;
  logic         vrf_wlast;
  logic         vrf_ready = 1'b0;
  logic         sb_wb_done;
  logic [7:0]   sb_wb_dst;
  logic         busy;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0]   dst;
    logic [1:0]   beat;
    logic [127:0] data;
    logic         last;
    int           cyc;
  } beat_t;
  typedef struct {
    logic [7:0] dst;
    int         cyc;
  } done_t;

  // These are recorded by the monitor as the DUT produces them and are compared against the model in the tasks.
  beat_t      obs_beats[$];
  done_t      obs_done[$];
  logic [7:0] acc_dst[$];
  int         acc_cyc[$];

  gsau_wb_drain dut (
    .CLK(clk), .RST(rst), .wb_valid(wb_valid), .wb_wbdst(wb_wbdst), .wb_data(wb_data),
    .wb_output_ready(wb_output_ready), .vrf_wen(vrf_wen), .vrf_waddr(vrf_waddr),
    .vrf_wbeat(vrf_wbeat), .vrf_wdata(vrf_wdata), .vrf_wlast(vrf_wlast),
    .vrf_ready(vrf_ready), .sb_wb_done(sb_wb_done), .sb_wb_dst(sb_wb_dst), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t bt;
    done_t dn;
    if (!rst) begin
      if (wb_valid && wb_output_ready) begin
        acc_dst.push_back(wb_wbdst);
        acc_cyc.push_back(cyc);
      end
      if (vrf_wen && vrf_ready) begin
        bt.dst = vrf_waddr; bt.beat = vrf_wbeat; bt.data = vrf_wdata;
        bt.last = vrf_wlast; bt.cyc = cyc;
        obs_beats.push_back(bt);
      end
      if (sb_wb_done) begin
        dn.dst = sb_wb_dst; dn.cyc = cyc;
        obs_done.push_back(dn);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: beat k of a row is bits [128k+127 : 128k], sent lowest beat first.
  function automatic logic [127:0] beat_of(input logic [511:0] d, input int k);
    return d[k*128 +: 128];
  endfunction

  task automatic test_reset();
    rst = 1'b1; wb_valid = 1'b1; wb_wbdst = 8'h11; vrf_ready = 1'b1;
    tick(); tick();
    n_checks++; if (wb_output_ready !== 1'b0) $display("FAIL rst_ready: got %b exp 0", wb_output_ready); else n_pass++;
    n_checks++; if (vrf_wen !== 1'b0) $display("FAIL rst_wen: got %b exp 0", vrf_wen); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
    n_checks++; if (sb_wb_done !== 1'b0) $display("FAIL rst_done: got %b exp 0", sb_wb_done); else n_pass++;
    wb_valid = 1'b0; rst = 1'b0;
    #1;
    n_checks++; if ({wb_output_ready, vrf_wen, busy, sb_wb_done, vrf_wdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 128'h0})
      $display("FAIL post_rst_outputs: got rdy=%b wen=%b busy=%b done=%b exp 1 0 0 0", wb_output_ready, vrf_wen, busy, sb_wb_done);
    else n_pass++;
  endtask

  task automatic test_single_row();
    int b0 = obs_beats.size();
    int d0 = obs_done.size();
    int a0 = acc_dst.size();
    vrf_ready = 1'b1;
    wb_valid = 1'b1; wb_wbdst = 8'h0A; wb_data = {16{32'hDEADBEEF}};
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < 30 && obs_done.size() < d0 + 1; i++) tick();
    n_checks++; if (obs_beats.size() - b0 !== 4) $display("FAIL single_beats: got %0d exp 4", obs_beats.size() - b0); else n_pass++;
    n_checks++; if (obs_done.size() - d0 !== 1) $display("FAIL single_done_cnt: got %0d exp 1", obs_done.size() - d0); else n_pass++;
    if (obs_beats.size() - b0 >= 4 && obs_done.size() > d0 && acc_cyc.size() > a0) begin
      for (int k = 0; k < 4; k++) begin
        beat_t b = obs_beats[b0 + k];
        n_checks++;
        if ({b.dst, b.beat, b.last, b.data} !== {8'h0A, 2'(k), (k == 3), {4{32'hDEADBEEF}}})
          $display("FAIL single_beat%0d: got dst=%h beat=%0d last=%b data=%h", k, b.dst, b.beat, b.last, b.data);
        else n_pass++;
        n_checks++; if (b.cyc !== obs_beats[b0].cyc + k) $display("FAIL single_consec%0d: got cyc %0d exp %0d", k, b.cyc, obs_beats[b0].cyc + k); else n_pass++;
      end
      n_checks++; if (obs_beats[b0].cyc < acc_cyc[a0] + 1) $display("FAIL single_bypass: beat0 cyc %0d push cyc %0d", obs_beats[b0].cyc, acc_cyc[a0]); else n_pass++;
      n_checks++; if ({obs_done[d0].dst, obs_done[d0].cyc} !== {8'h0A, obs_beats[b0 + 3].cyc + 1})
        $display("FAIL single_done: got dst=%h cyc=%0d exp dst=0a cyc=%0d", obs_done[d0].dst, obs_done[d0].cyc, obs_beats[b0 + 3].cyc + 1);
      else n_pass++;
    end
    tick(); tick(); tick();
    n_checks++; if (obs_done.size() - d0 !== 1) $display("FAIL single_one_pulse: got %0d exp 1", obs_done.size() - d0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    int b0 = obs_beats.size();
    int d0 = obs_done.size();
    logic [138:0] held;
    vrf_ready = 1'b1;
    wb_valid = 1'b1; wb_wbdst = 8'h21; wb_data = {16{32'hCAFEBABE}};
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < 20 && !(vrf_wen && vrf_wbeat == 2'd1); i++) tick();
    n_checks++; if ({vrf_wen, vrf_wbeat} !== 3'b101) $display("FAIL bp_reach_beat1: got wen=%b beat=%0d exp 1 1", vrf_wen, vrf_wbeat); else n_pass++;
    vrf_ready = 1'b0;
    held = {vrf_waddr, vrf_wbeat, vrf_wlast, vrf_wdata};
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({vrf_wen, vrf_waddr, vrf_wbeat, vrf_wlast, vrf_wdata} !== {1'b1, 8'h21, 2'd1, 1'b0, {4{32'hCAFEBABE}}} || {vrf_waddr, vrf_wbeat, vrf_wlast, vrf_wdata} !== held)
        $display("FAIL bp_hold%0d: got wen=%b dst=%h beat=%0d last=%b exp 1 21 1 0", i, vrf_wen, vrf_waddr, vrf_wbeat, vrf_wlast);
      else n_pass++;
    end
    vrf_ready = 1'b1;
    for (int i = 0; i < 20 && obs_done.size() < d0 + 1; i++) tick();
    tick();
    n_checks++; if (obs_beats.size() - b0 !== 4) $display("FAIL bp_handshakes: got %0d exp 4", obs_beats.size() - b0); else n_pass++;
    n_checks++; if (obs_done.size() - d0 !== 1) $display("FAIL bp_done_cnt: got %0d exp 1", obs_done.size() - d0); else n_pass++;
    if (obs_beats.size() - b0 >= 4) begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if ({obs_beats[b0 + k].dst, obs_beats[b0 + k].beat, obs_beats[b0 + k].last} !== {8'h21, 2'(k), (k == 3)})
          $display("FAIL bp_beat%0d: got dst=%h beat=%0d last=%b", k, obs_beats[b0 + k].dst, obs_beats[b0 + k].beat, obs_beats[b0 + k].last);
        else n_pass++;
      end
    end
  endtask

  task automatic test_fill_full();
    int b0 = obs_beats.size();
    int d0 = obs_done.size();
    int a0 = acc_dst.size();
    logic [7:0] exp_dst [2] = '{8'h01, 8'h02};
    vrf_ready = 1'b0;
    wb_valid = 1'b1; wb_wbdst = 8'h01; wb_data = {16{32'h01010101}};
    tick();
    n_checks++; if (wb_output_ready !== 1'b1) $display("FAIL full_ready_after1: got %b exp 1", wb_output_ready); else n_pass++;
    wb_wbdst = 8'h02; wb_data = {16{32'h02020202}};
    tick();
    n_checks++; if (wb_output_ready !== 1'b0) $display("FAIL full_ready_after2: got %b exp 0", wb_output_ready); else n_pass++;
    wb_wbdst = 8'h03; wb_data = {16{32'h03030303}};
    tick();
    wb_valid = 1'b0;
    n_checks++; if (acc_dst.size() - a0 !== 2) $display("FAIL full_accepted: got %0d exp 2", acc_dst.size() - a0); else n_pass++;
    n_checks++; if (wb_output_ready !== 1'b0) $display("FAIL full_still_full: got %b exp 0", wb_output_ready); else n_pass++;
    vrf_ready = 1'b1;
    for (int i = 0; i < 40 && obs_done.size() < d0 + 2; i++) tick();
    n_checks++; if (obs_beats.size() - b0 !== 8) $display("FAIL full_beats: got %0d exp 8", obs_beats.size() - b0); else n_pass++;
    if (obs_beats.size() - b0 >= 8 && obs_done.size() - d0 >= 2) begin
      for (int k = 0; k < 8; k++) begin
        beat_t b = obs_beats[b0 + k];
        n_checks++;
        if ({b.dst, b.beat, b.cyc} !== {exp_dst[k / 4], 2'(k % 4), obs_beats[b0].cyc + k})
          $display("FAIL full_beat%0d: got dst=%h beat=%0d cyc=%0d exp dst=%h beat=%0d cyc=%0d", k, b.dst, b.beat, b.cyc, exp_dst[k / 4], k % 4, obs_beats[b0].cyc + k);
        else n_pass++;
      end
      for (int r = 0; r < 2; r++) begin
        n_checks++; if (obs_done[d0 + r].dst !== exp_dst[r]) $display("FAIL full_done%0d: got %h exp %h", r, obs_done[d0 + r].dst, exp_dst[r]); else n_pass++;
      end
    end
  endtask

  task automatic test_simul_push_pop();
    int d0 = obs_done.size();
    vrf_ready = 1'b1;
    wb_valid = 1'b1; wb_wbdst = 8'h04; wb_data = {16{32'h44444444}};
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < 20 && !(vrf_wen && vrf_wlast); i++) tick();
    n_checks++; if ({vrf_wen, vrf_wlast, vrf_waddr, wb_output_ready} !== {2'b11, 8'h04, 1'b1})
      $display("FAIL sim_reach_last: got wen=%b last=%b dst=%h rdy=%b", vrf_wen, vrf_wlast, vrf_waddr, wb_output_ready);
    else n_pass++;
    wb_valid = 1'b1; wb_wbdst = 8'h05; wb_data = {16{32'h55555555}};
    tick();
    wb_valid = 1'b0;
    n_checks++; if ({vrf_wen, vrf_waddr, vrf_wbeat, vrf_wdata} !== {1'b1, 8'h05, 2'd0, {4{32'h55555555}}})
      $display("FAIL sim_next_row: got wen=%b dst=%h beat=%0d exp 1 05 0", vrf_wen, vrf_waddr, vrf_wbeat);
    else n_pass++;
    // One entry left after the simultaneous push and pop, so the FIFO is not full.
    n_checks++; if (wb_output_ready !== 1'b1) $display("FAIL sim_occupancy: got rdy=%b exp 1", wb_output_ready); else n_pass++;
    for (int i = 0; i < 20 && obs_done.size() < d0 + 2; i++) tick();
    n_checks++; if (obs_done.size() - d0 !== 2) $display("FAIL sim_done_cnt: got %0d exp 2", obs_done.size() - d0); else n_pass++;
  endtask

  task automatic test_beat_order();
    int b0 = obs_beats.size();
    int d0 = obs_done.size();
    logic [511:0] d;
    for (int k = 0; k < 4; k++) d[k*128 +: 128] = {32{4'(k)}};
    vrf_ready = 1'b1;
    wb_valid = 1'b1; wb_wbdst = 8'h33; wb_data = d;
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < 20 && obs_done.size() < d0 + 1; i++) tick();
    n_checks++; if (obs_beats.size() - b0 !== 4) $display("FAIL order_beats: got %0d exp 4", obs_beats.size() - b0); else n_pass++;
    if (obs_beats.size() - b0 >= 4) begin
      for (int k = 0; k < 4; k++) begin
        logic [127:0] e = {32{4'(k)}};
        n_checks++; if (obs_beats[b0 + k].data !== e) $display("FAIL order_beat%0d: got %h exp %h", k, obs_beats[b0 + k].data, e); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int b0, d0;
    logic [511:0] d;
    vrf_ready = 1'b1;
    wb_valid = 1'b1; wb_wbdst = 8'h0B; wb_data = {16{32'hBBBBBBBB}};
    tick();
    wb_wbdst = 8'h0D; wb_data = {16{32'hDDDDDDDD}};
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < 20 && !(vrf_wen && vrf_wbeat == 2'd2); i++) tick();
    n_checks++; if ({vrf_wen, vrf_wbeat, vrf_waddr} !== {1'b1, 2'd2, 8'h0B}) $display("FAIL rmid_reach: got wen=%b beat=%0d dst=%h", vrf_wen, vrf_wbeat, vrf_waddr); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if ({vrf_wen, wb_output_ready, busy} !== 3'b000) $display("FAIL rmid_forced: got wen=%b rdy=%b busy=%b exp 000", vrf_wen, wb_output_ready, busy); else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    b0 = obs_beats.size(); d0 = obs_done.size();
    n_checks++; if ({wb_output_ready, vrf_wen, busy, sb_wb_done} !== 4'b1000) $display("FAIL rmid_release: got rdy=%b wen=%b busy=%b done=%b exp 1000", wb_output_ready, vrf_wen, busy, sb_wb_done); else n_pass++;
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if ({obs_beats.size() - b0, obs_done.size() - d0} !== {32'd0, 32'd0})
      $display("FAIL rmid_discard: got beats=%0d dones=%0d exp 0 0", obs_beats.size() - b0, obs_done.size() - d0);
    else n_pass++;
    for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom();
    wb_valid = 1'b1; wb_wbdst = 8'h0C; wb_data = d;
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < 20 && obs_done.size() < d0 + 1; i++) tick();
    n_checks++; if (obs_beats.size() - b0 !== 4 || obs_done.size() - d0 !== 1) $display("FAIL rmid_new_cnt: got beats=%0d dones=%0d exp 4 1", obs_beats.size() - b0, obs_done.size() - d0); else n_pass++;
    if (obs_beats.size() - b0 >= 4 && obs_done.size() > d0) begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if ({obs_beats[b0 + k].dst, obs_beats[b0 + k].beat, obs_beats[b0 + k].data} !== {8'h0C, 2'(k), beat_of(d, k)})
          $display("FAIL rmid_beat%0d: got dst=%h beat=%0d data=%h", k, obs_beats[b0 + k].dst, obs_beats[b0 + k].beat, obs_beats[b0 + k].data);
        else n_pass++;
      end
      n_checks++; if (obs_done[d0].dst !== 8'h0C) $display("FAIL rmid_done: got %h exp 0c", obs_done[d0].dst); else n_pass++;
    end
  endtask

  task automatic test_random();
    localparam int N = 40;
    logic [7:0]   r_dst [N];
    logic [511:0] r_dat [N];
    int b0 = obs_beats.size();
    int d0 = obs_done.size();
    int a0 = acc_dst.size();
    int idx = 0;
    int occ;
    logic hold_pend;
    logic [138:0] held;
    for (int i = 0; i < N; i++) begin
      r_dst[i] = 8'($urandom());
      for (int j = 0; j < 16; j++) r_dat[i][j*32 +: 32] = $urandom();
    end
    for (int c = 0; c < 4000 && obs_done.size() < d0 + N; c++) begin
      vrf_ready = ($urandom_range(0, 9) < 7);
      if (idx < N) begin
        wb_valid = 1'($urandom_range(0, 1));
        wb_wbdst = r_dst[idx]; wb_data = r_dat[idx];
      end else begin
        wb_valid = 1'b0;
      end
      hold_pend = vrf_wen && !vrf_ready;
      held = {vrf_waddr, vrf_wbeat, vrf_wlast, vrf_wdata};
      tick();
      if (acc_dst.size() - a0 > idx) idx++;
      if (hold_pend) begin
        n_checks++; if ({vrf_wen, vrf_waddr, vrf_wbeat, vrf_wlast, vrf_wdata} !== {1'b1, held})
          $display("FAIL rnd_hold: got wen=%b dst=%h beat=%0d exp held dst=%h beat=%0d", vrf_wen, vrf_waddr, vrf_wbeat, held[138:131], held[130:129]);
        else n_pass++;
      end
      // Occupancy = rows accepted minus rows whose final beat has been written.
      occ = (acc_dst.size() - a0) - (obs_beats.size() - b0) / 4;
      n_checks++; if (wb_output_ready !== (occ < 2)) $display("FAIL rnd_ready: got %b exp %b occ=%0d", wb_output_ready, (occ < 2), occ); else n_pass++;
    end
    wb_valid = 1'b0;
    tick();
    n_checks++; if (obs_done.size() - d0 !== N || obs_beats.size() - b0 !== 4 * N)
      $display("FAIL rnd_counts: got dones=%0d beats=%0d exp %0d %0d", obs_done.size() - d0, obs_beats.size() - b0, N, 4 * N);
    else n_pass++;
    if (obs_done.size() - d0 >= N && obs_beats.size() - b0 >= 4 * N) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < 4; k++) begin
          beat_t b = obs_beats[b0 + 4 * i + k];
          n_checks++;
          if ({b.dst, b.beat, b.last, b.data} !== {r_dst[i], 2'(k), (k == 3), beat_of(r_dat[i], k)})
            $display("FAIL rnd_beat r%0d b%0d: got dst=%h beat=%0d last=%b data=%h exp dst=%h", i, k, b.dst, b.beat, b.last, b.data, r_dst[i]);
          else n_pass++;
        end
        n_checks++;
        if ({obs_done[d0 + i].dst, obs_done[d0 + i].cyc} !== {r_dst[i], obs_beats[b0 + 4 * i + 3].cyc + 1})
          $display("FAIL rnd_done r%0d: got dst=%h cyc=%0d exp dst=%h cyc=%0d", i, obs_done[d0 + i].dst, obs_done[d0 + i].cyc, r_dst[i], obs_beats[b0 + 4 * i + 3].cyc + 1);
        else n_pass++;
      end
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL rnd_final_busy: got %b exp 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_backpressure();
    test_fill_full();
    test_simul_push_pop();
    test_beat_order();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
